decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-003 SHALL have ports: id_valid  input  1  decode holds an instruction; id_rs1, id_rs2  input  GPR_ENCODE_BITS  source indices; id_use_rs1, id_use_rs2  input  1  source actually read.
REQ-004 SHALL have ports: id_rd  input  GPR_ENCODE_BITS  destination; id_we  input  1  instruction writes id_rd.
REQ-005 SHALL have ports: ex_ready  input  1  execute accepts; id_ready  output  1  issue permitted this cycle.
REQ-006 SHALL have ports: wb_we  input  1, wb_rd  input  GPR_ENCODE_BITS  writeback retire, same signals that drive the register-file write port.
REQ-007 SHALL have ports: flush  input  1  discard all in-flight writes; busy_any  output  1  any counter non-zero; stall_cnt  output  32  saturating stall-cycle count.

Function
REQ-008 SHALL keep one 2-bit pending-write counter per GPR (GPRS_COUNT entries); counter for index 0 SHALL be constant 0.
REQ-009 SHALL define fire = id_valid & id_ready; on fire with id_we=1 and id_rd!=0, counter[id_rd] increments.
REQ-010 SHALL decrement counter[wb_rd] when wb_we=1, wb_rd!=0 and counter non-zero; a retire to a zero counter SHALL be ignored (no underflow).
REQ-011 SHALL leave counter unchanged when increment and decrement target the same index in the same cycle.
REQ-012 SHALL treat a used source s as busy when counter[s]!=0, except not busy when counter[s]==1 and wb_we=1 and wb_rd==s in the same cycle (register file writes on negedge, value readable that cycle).
REQ-013 SHALL treat destination as blocked when id_we=1, id_rd!=0, counter[id_rd]==3 and no same-cycle retire to id_rd.
REQ-014 SHALL drive id_ready = ex_ready & ~flush & no busy used source & ~destination blocked; purely combinational, zero latency; id_ready SHALL NOT depend on id_valid.
REQ-015 SHALL, on flush=1, clear all counters next cycle, suppress any issue that cycle, and ignore the same-cycle retire; upstream guarantees no pre-flush instruction retires after flush.
REQ-016 SHALL increment stall_cnt when id_valid=1, id_ready=0, flush=0; stall_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-017 SHALL drive busy_any from registered counters (reflects state after last edge).
REQ-018 SHALL ignore id_rs*, id_rd, id_we when id_valid=0; sources with id_use_rs*=0 SHALL never cause a stall.

Reset
REQ-019 SHALL, with rst_n=0 at posedge, clear all counters and stall_cnt; reset SHALL take priority over flush, fire and retire.
REQ-020 SHALL drive after reset: busy_any=0, stall_cnt=0, id_ready=ex_ready.
REQ-021 SHALL, on reset mid-operation, drop all pending state with no retire processed in that cycle.

Structure
REQ-022 SHALL take XLEN, GPR_ENCODE_BITS and GPRS_COUNT from the shared constants file; a new SCOREBOARD_CNT_BITS (=2) constant SHALL be added there.
REQ-023 SHALL place per-register counter logic (inc, dec, clear, saturation query) in one sub-module scoreboard_cell, instantiated GPRS_COUNT-1 times.
REQ-024 SHALL contain no latches and no negedge logic.

Verification
REQ-025 SHALL cover: issue rd=5 we=1, next cycle rs1=5 used, no retire -> id_ready=0 until wb_we=1 wb_rd=5, id_ready=1 in that retire cycle.
REQ-026 SHALL cover: three issues to rd=7 without retire -> fourth issue to rd=7 stalled (id_ready=0); retire rd=7 same cycle -> id_ready=1, counter stays 3.
REQ-027 SHALL cover: issue rd=0 we=1 then read rs1=0 -> never stalls, busy_any stays 0.
REQ-028 SHALL cover: counters for x3,x9 non-zero, flush=1 -> id_ready=0 that cycle, busy_any=0 next cycle; wb_we=1 wb_rd=3 afterwards -> ignored.
REQ-029 SHALL cover: id_valid=1 held stalled 10 cycles -> stall_cnt=10; preload near max -> saturates at 32'hFFFF_FFFF.
REQ-030 SHALL cover: rst_n=0 asserted while counters non-zero and fire/retire active -> all counters 0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// Shared core constants and scoreboard types.
package decode_scoreboard_pkg;

   localparam int unsigned XLEN                = 32;
   localparam int unsigned GPR_ENCODE_BITS     = 5;
   localparam int unsigned GPRS_COUNT          = 32;
   localparam int unsigned SCOREBOARD_CNT_BITS = 2;

   typedef logic [GPR_ENCODE_BITS-1:0]     gpr_idx_t;
   typedef logic [SCOREBOARD_CNT_BITS-1:0] sb_cnt_t;

   localparam sb_cnt_t SbCntMax = '1;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode/execute/writeback signals seen by the issue scoreboard.
interface decode_scoreboard_if;
   import decode_scoreboard_pkg::*;

   logic            id_valid;
   gpr_idx_t        id_rs1;
   gpr_idx_t        id_rs2;
   logic            id_use_rs1;
   logic            id_use_rs2;
   gpr_idx_t        id_rd;
   logic            id_we;
   logic            ex_ready;
   logic            id_ready;
   logic            wb_we;
   gpr_idx_t        wb_rd;
   logic            flush;
   logic            busy_any;
   logic [XLEN-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
      output ex_ready, wb_we, wb_rd, flush,
      input  id_ready, busy_any, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we,
      input  ex_ready, wb_we, wb_rd, flush,
      output id_ready, busy_any, stall_cnt
   );

endinterface

// File: rtl/scoreboard_cell.sv
// Pending-write counter for a single GPR.
module scoreboard_cell
   import decode_scoreboard_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    inc,
   input  logic    dec,
   input  logic    clr,
   output sb_cnt_t cnt,
   output logic    full
);

   sb_cnt_t cnt_q;
   sb_cnt_t cnt_d;
   logic    dec_eff;

   always_comb begin
      // A retire against an empty counter is dropped, so it cannot cancel an increment.
      dec_eff = dec & (cnt_q != '0);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec_eff && cnt_q != SbCntMax) begin
         cnt_d = cnt_q + sb_cnt_t'(1);
      end else if (dec_eff && !inc) begin
         cnt_d = cnt_q - sb_cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign full = (cnt_q == SbCntMax);

endmodule

// File: rtl/decode_scoreboard.sv
// Issue scoreboard: tracks in-flight GPR writes and gates decode issue on RAW/WAW hazards.
module decode_scoreboard
   import decode_scoreboard_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   decode_scoreboard_if.slave sb
);

   sb_cnt_t               cnt [GPRS_COUNT];
   logic [GPRS_COUNT-1:0] full;
   logic [GPRS_COUNT-1:0] nonzero;
   logic                  fire;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  rd_blocked;
   logic [XLEN-1:0]       stall_q;
   logic [XLEN-1:0]       stall_d;

   assign cnt[0]  = '0;
   assign full[0] = 1'b0;
   assign fire    = sb.id_valid & sb.id_ready;

   for (genvar i = 1; i < GPRS_COUNT; i++) begin : g_cell
      scoreboard_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (fire & sb.id_we & (sb.id_rd == gpr_idx_t'(i))),
         .dec   (sb.wb_we & ~sb.flush & (sb.wb_rd == gpr_idx_t'(i))),
         .clr   (sb.flush),
         .cnt   (cnt[i]),
         .full  (full[i])
      );
   end

   always_comb begin
      // Last outstanding write retiring now is bypassed by the negedge register-file write.
      rs1_busy = sb.id_use_rs1 & (cnt[sb.id_rs1] != '0)
               & ~((cnt[sb.id_rs1] == sb_cnt_t'(1)) & sb.wb_we & (sb.wb_rd == sb.id_rs1));
      rs2_busy = sb.id_use_rs2 & (cnt[sb.id_rs2] != '0)
               & ~((cnt[sb.id_rs2] == sb_cnt_t'(1)) & sb.wb_we & (sb.wb_rd == sb.id_rs2));
      rd_blocked = sb.id_we & (sb.id_rd != '0) & full[sb.id_rd]
                 & ~(sb.wb_we & (sb.wb_rd == sb.id_rd));
      sb.id_ready = sb.ex_ready & ~sb.flush & ~rs1_busy & ~rs2_busy & ~rd_blocked;
   end

   always_comb begin
      nonzero = '0;
      for (int i = 0; i < GPRS_COUNT; i++) begin
         nonzero[i] = (cnt[i] != '0);
      end
   end

   assign sb.busy_any = |nonzero;

   always_comb begin
      stall_d = stall_q;
      if (sb.id_valid && !sb.id_ready && !sb.flush && stall_q != '1) begin
         stall_d = stall_q + XLEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign sb.stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard with hand-computed expectations.
module tb_decode_scoreboard;
   import decode_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   decode_scoreboard_if bus ();

   decode_scoreboard dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid   = 1'b0;
      bus.id_rs1     = '0;
      bus.id_rs2     = '0;
      bus.id_use_rs1 = 1'b0;
      bus.id_use_rs2 = 1'b0;
      bus.id_rd      = '0;
      bus.id_we      = 1'b0;
      bus.wb_we      = 1'b0;
      bus.wb_rd      = '0;
      bus.flush      = 1'b0;
      bus.ex_ready   = 1'b1;
      #1;
   endtask

   task automatic issue(input gpr_idx_t rd, input logic we, input gpr_idx_t rs1, input logic u1,
                        input gpr_idx_t rs2, input logic u2);
      bus.id_valid   = 1'b1;
      bus.id_rd      = rd;
      bus.id_we      = we;
      bus.id_rs1     = rs1;
      bus.id_use_rs1 = u1;
      bus.id_rs2     = rs2;
      bus.id_use_rs2 = u2;
      #1;
   endtask

   task automatic retire(input gpr_idx_t rd);
      bus.wb_we = 1'b1;
      bus.wb_rd = rd;
      #1;
   endtask

   initial begin
      // Reset and idle behaviour
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      idle();
      chk("rst_busy", 32'(bus.busy_any), 32'd0);
      chk("rst_stall", bus.stall_cnt, 32'd0);
      chk("rst_ready", 32'(bus.id_ready), 32'd1);
      bus.ex_ready = 1'b0;
      #1;
      chk("ready_follows_ex", 32'(bus.id_ready), 32'd0);
      idle();

      // RAW on x5 released in the retire cycle
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("raw_issue", 32'(bus.id_ready), 32'd1);
      tick();
      issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("raw_stall", 32'(bus.id_ready), 32'd0);
      chk("raw_busy", 32'(bus.busy_any), 32'd1);
      tick();
      retire(5'd5);
      chk("raw_bypass", 32'(bus.id_ready), 32'd1);
      tick();
      idle();
      chk("raw_drained", 32'(bus.busy_any), 32'd0);
      chk("raw_stall_cnt", bus.stall_cnt, 32'd1);

      // Unused source never stalls
      issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0);
      chk("unused_src", 32'(bus.id_ready), 32'd1);
      tick();
      idle();
      retire(5'd6);
      tick();
      idle();

      // WAW saturation on x7
      for (int i = 0; i < 3; i++) begin
         issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
         chk("waw_fill", 32'(bus.id_ready), 32'd1);
         tick();
      end
      chk("waw_busy", 32'(bus.busy_any), 32'd1);
      chk("waw_block", 32'(bus.id_ready), 32'd0);
      tick();
      retire(5'd7);
      chk("waw_retire_same", 32'(bus.id_ready), 32'd1);
      tick();
      bus.wb_we = 1'b0;
      #1;
      chk("waw_still_full", 32'(bus.id_ready), 32'd0);
      tick();
      idle();
      retire(5'd7);
      tick();
      tick();
      tick();
      idle();
      chk("waw_drained", 32'(bus.busy_any), 32'd0);
      chk("waw_stall_cnt", bus.stall_cnt, 32'd3);

      // x0 is never tracked
      issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("x0_issue", 32'(bus.id_ready), 32'd1);
      tick();
      issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
      chk("x0_read", 32'(bus.id_ready), 32'd1);
      chk("x0_busy", 32'(bus.busy_any), 32'd0);
      tick();
      idle();

      // Flush with x3 and x9 pending
      issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle();
      chk("flush_pre_busy", 32'(bus.busy_any), 32'd1);
      issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      bus.flush = 1'b1;
      retire(5'd3);
      chk("flush_ready", 32'(bus.id_ready), 32'd0);
      tick();
      idle();
      chk("flush_cleared", 32'(bus.busy_any), 32'd0);
      chk("flush_no_stall", bus.stall_cnt, 32'd3);
      retire(5'd3);
      tick();
      idle();
      issue(5'd0, 1'b0, 5'd3, 1'b1, 5'd10, 1'b1);
      chk("flush_late_retire", 32'(bus.id_ready), 32'd1);
      chk("flush_late_busy", 32'(bus.busy_any), 32'd0);
      tick();
      idle();

      // Stall counting and saturation
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.ex_ready = 1'b0;
      issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      bus.id_valid = 1'b0;
      #1;
      chk("stall_ten", bus.stall_cnt, 32'd10);
      bus.id_valid = 1'b1;
      force dut.stall_q = 32'hFFFF_FFFD;
      #1;
      release dut.stall_q;
      tick();
      chk("stall_near_max", bus.stall_cnt, 32'hFFFF_FFFE);
      tick();
      tick();
      chk("stall_saturate", bus.stall_cnt, 32'hFFFF_FFFF);
      idle();

      // Reset mid-operation with issue and retire active
      issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      tick();
      chk("rst_mid_busy", 32'(bus.busy_any), 32'd1);
      retire(5'd4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      chk("rst_mid_cleared", 32'(bus.busy_any), 32'd0);
      chk("rst_mid_stall", bus.stall_cnt, 32'd0);
      issue(5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
      chk("rst_mid_ready", 32'(bus.id_ready), 32'd1);
      tick();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
